// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for the single-ported data memory.
// Port C is the core load/store unit and port D is the debug/loader port.
// Accesses are serialised IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP (1 cycle).
// Ties go round-robin, and the response goes only to the port that won.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // Debug port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory port
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q;
  logic                last_q;   // 0 = C served last, 1 = D served last
  logic                win_q;    // 0 = C owns the current access, 1 = D
  logic [3:0]          cnt_q;
  logic                c_gnt_q, d_gnt_q, c_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   c_rdata_q, d_rdata_q;
  logic                m_en_q, m_we_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;

  logic                pick_d;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W-1:0]   cap_data;

  // Winner selection and request mux; a tie goes to the port not served last.
  always_comb begin
    pick_d = d_req;
    if (c_req && d_req) begin
      pick_d = ~last_q;
    end
    sel_we    = pick_d ? d_we    : c_we;
    sel_addr  = pick_d ? d_addr  : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
    // Writes report zero read data.
    cap_data  = m_we_q ? '0 : m_rdata;
  end

  // Sequencing FSM with registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      c_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      c_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      m_en_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (c_req || d_req) begin
            win_q     <= pick_d;
            last_q    <= pick_d;
            c_gnt_q   <= ~pick_d;
            d_gnt_q   <= pick_d;
            m_en_q    <= 1'b1;
            m_we_q    <= sel_we;
            m_addr_q  <= sel_addr;
            m_wdata_q <= sel_wdata;
            cnt_q     <= LatCnt;
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            if (win_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= cap_data;
            end else begin
              c_rvalid_q <= 1'b1;
              c_rdata_q  <= cap_data;
            end
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign c_gnt    = c_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each backed by a behavioural memory that returns a poison word outside its read window.
module tb_dmem_arbiter;

  localparam logic [63:0] Bad = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        c_req0, c_we0, d_req0, d_we0;
  logic [9:0]  c_addr0, d_addr0, m_addr0;
  logic [63:0] c_wdata0, d_wdata0, c_rdata0, d_rdata0, m_wdata0, m_rdata0;
  logic        c_gnt0, c_rvalid0, d_gnt0, d_rvalid0, m_en0, m_we0, busy0;

  // MEM_LAT = 3 instance, debug port tied off
  logic        c_req3;
  logic [9:0]  c_addr3, m_addr3;
  logic [63:0] c_rdata3, d_rdata3, m_wdata3, m_rdata3;
  logic        c_gnt3, c_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3, busy3;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(1)) u0 (
    .clk(clk), .rst(rst),
    .c_req(c_req0), .c_we(c_we0), .c_addr(c_addr0), .c_wdata(c_wdata0),
    .c_gnt(c_gnt0), .c_rvalid(c_rvalid0), .c_rdata(c_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(m_rdata0), .busy(busy0)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .c_req(c_req3), .c_we(1'b0), .c_addr(c_addr3), .c_wdata(64'd0),
    .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(10'd0), .d_wdata(64'd0),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_rdata(m_rdata3), .busy(busy3)
  );

  // Behavioural memories with a bench-side load port
  logic [63:0] mem0 [1024];
  logic [63:0] mem3 [1024];
  logic        ld0, ld3;
  logic [9:0]  ld_a0, ld_a3;
  logic [63:0] ld_d0, ld_d3;
  logic        pv0;
  logic [63:0] pd0;
  logic [2:0]  pv3;
  logic [63:0] pd3 [3];

  always @(posedge clk) begin
    if (ld0) mem0[ld_a0] <= ld_d0;
    if (m_en0 && m_we0) mem0[m_addr0] <= m_wdata0;
    pv0 <= m_en0 && !m_we0;
    pd0 <= mem0[m_addr0];
  end
  assign m_rdata0 = pv0 ? pd0 : Bad;

  always @(posedge clk) begin
    if (ld3) mem3[ld_a3] <= ld_d3;
    if (m_en3 && m_we3) mem3[m_addr3] <= m_wdata3;
    pv3    <= {pv3[1:0], m_en3 && !m_we3};
    pd3[0] <= mem3[m_addr3];
    pd3[1] <= pd3[0];
    pd3[2] <= pd3[1];
  end
  assign m_rdata3 = pv3[2] ? pd3[2] : Bad;

  // Scoreboard queues
  logic [63:0] exp_c0 [$];
  logic [63:0] exp_d0 [$];
  logic [63:0] exp_c3 [$];
  logic [1:0]  exp_g0 [$];   // 2'b10 = C grant, 2'b01 = D grant

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare responses and grants against the queues
  always @(negedge clk) begin
    chk("rvalid_overlap", {63'd0, c_rvalid0 & d_rvalid0}, 64'd0);
    if (c_rvalid0) begin
      if (exp_c0.size() == 0) chk("c0_spurious_rvalid", {63'd0, c_rvalid0}, 64'd0);
      else chk("c0_rdata", c_rdata0, exp_c0.pop_front());
    end
    if (d_rvalid0) begin
      if (exp_d0.size() == 0) chk("d0_spurious_rvalid", {63'd0, d_rvalid0}, 64'd0);
      else chk("d0_rdata", d_rdata0, exp_d0.pop_front());
    end
    if (c_gnt0 || d_gnt0) begin
      if (exp_g0.size() == 0) chk("g0_spurious", {62'd0, c_gnt0, d_gnt0}, 64'd0);
      else chk("g0_order", {62'd0, c_gnt0, d_gnt0}, {62'd0, exp_g0.pop_front()});
    end
    if (c_rvalid3) begin
      if (exp_c3.size() == 0) chk("c3_spurious_rvalid", {63'd0, c_rvalid3}, 64'd0);
      else chk("c3_rdata", c_rdata3, exp_c3.pop_front());
    end
    chk("u3_d_quiet", d_rdata3 | {62'd0, d_gnt3, d_rvalid3}, 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [9:0] a, input logic [63:0] v);
    ld0 = 1'b1; ld_a0 = a; ld_d0 = v;
    tick();
    ld0 = 1'b0;
  endtask

  task automatic dbg_write(input logic [9:0] a, input logic [63:0] v);
    d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = a; d_wdata0 = v;
    exp_g0.push_back(2'b01);
    exp_d0.push_back(64'd0);
    tick();
    for (int k = 0; k < 20 && !d_gnt0; k++) tick();
    chk("dw_gnt_seen", {63'd0, d_gnt0}, 64'd1);
    d_req0 = 1'b0; d_we0 = 1'b0;
    for (int k = 0; k < 20 && !d_rvalid0; k++) tick();
    chk("dw_rvalid_seen", {63'd0, d_rvalid0}, 64'd1);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    c_req0 = 0; c_we0 = 0; c_addr0 = '0; c_wdata0 = '0;
    d_req0 = 0; d_we0 = 0; d_addr0 = '0; d_wdata0 = '0;
    c_req3 = 0; c_addr3 = '0;
    ld0 = 0; ld_a0 = '0; ld_d0 = '0;
    ld3 = 0; ld_a3 = '0; ld_d3 = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_outs", {59'd0, c_gnt0, d_gnt0, c_rvalid0, d_rvalid0, m_en0}, 64'd0);
    chk("rst_maddr", {54'd0, m_addr0}, 64'd0);
    chk("rst_rdata", c_rdata0 | d_rdata0 | m_wdata0, 64'd0);

    load0(10'd3, 64'd7);
    load0(10'd10, 64'h1111);
    load0(10'd20, 64'h2222);
    ld3 = 1'b1; ld_a3 = 10'd1; ld_d3 = 64'd42;
    tick();
    ld3 = 1'b0;
    rst = 1'b1;
    tick();

    // Core read with MEM_LAT=1
    c_req0 = 1'b1; c_addr0 = 10'd3;
    exp_g0.push_back(2'b10);
    exp_c0.push_back(64'd7);
    tick();
    chk("t1_c1_gnt", {63'd0, c_gnt0}, 64'd1);
    chk("t1_c1_men", {63'd0, m_en0}, 64'd1);
    chk("t1_c1_maddr", {54'd0, m_addr0}, 64'd3);
    chk("t1_c1_busy", {63'd0, busy0}, 64'd1);
    c_req0 = 1'b0;
    tick();
    chk("t1_c2_gnt_men", {62'd0, c_gnt0, m_en0}, 64'd0);
    chk("t1_c2_maddr", {54'd0, m_addr0}, 64'd3);
    chk("t1_c2_busy_rv", {62'd0, busy0, c_rvalid0}, 64'd2);
    tick();
    chk("t1_c3_rvalid", {63'd0, c_rvalid0}, 64'd1);
    chk("t1_c3_busy", {63'd0, busy0}, 64'd1);
    chk("t1_c3_maddr", {54'd0, m_addr0}, 64'd0);
    tick();
    chk("t1_c4_idle", {62'd0, busy0, c_rvalid0}, 64'd0);

    // Tie and fairness right after reset
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    c_req0 = 1'b1; c_addr0 = 10'd10;
    d_req0 = 1'b1; d_addr0 = 10'd20;
    for (int i = 0; i < 2; i++) begin
      exp_g0.push_back(2'b10);
      exp_g0.push_back(2'b01);
      exp_c0.push_back(64'h1111);
      exp_d0.push_back(64'h2222);
    end
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      chk($sformatf("t2_cgnt_c%0d", cyc), {63'd0, c_gnt0}, {63'd0, cyc == 1 || cyc == 9});
      chk($sformatf("t2_dgnt_c%0d", cyc), {63'd0, d_gnt0}, {63'd0, cyc == 5 || cyc == 13});
    end
    c_req0 = 1'b0; d_req0 = 1'b0;
    repeat (4) tick();

    // Debug preload then core readback
    for (int i = 0; i < 5; i++) dbg_write(10'(i), 64'(5 - i));
    c_req0 = 1'b1; c_we0 = 1'b0; c_addr0 = 10'd0;
    exp_g0.push_back(2'b10);
    exp_c0.push_back(64'd5);
    tick();
    for (int k = 0; k < 20 && !c_gnt0; k++) tick();
    chk("t3_cgnt_seen", {63'd0, c_gnt0}, 64'd1);
    c_req0 = 1'b0;
    for (int k = 0; k < 20 && !c_rvalid0; k++) tick();
    chk("t3_crv_seen", {63'd0, c_rvalid0}, 64'd1);
    tick();
    for (int i = 0; i < 5; i++) chk($sformatf("t3_mem%0d", i), mem0[i], 64'(5 - i));

    // Latency scaling with MEM_LAT=3; request held to observe the next accept
    c_req3 = 1'b1; c_addr3 = 10'd1;
    exp_c3.push_back(64'd42);
    exp_c3.push_back(64'd42);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      chk($sformatf("t4_men_c%0d", cyc), {63'd0, m_en3}, {63'd0, cyc == 1 || cyc == 7});
      chk($sformatf("t4_gnt_c%0d", cyc), {63'd0, c_gnt3}, {63'd0, cyc == 1 || cyc == 7});
      chk($sformatf("t4_rv_c%0d", cyc), {63'd0, c_rvalid3}, {63'd0, cyc == 5});
      chk($sformatf("t4_busy_c%0d", cyc), {63'd0, busy3}, {63'd0, cyc != 6});
      if (cyc >= 2 && cyc <= 4) chk($sformatf("t4_maddr_c%0d", cyc), {54'd0, m_addr3}, 64'd1);
    end
    c_req3 = 1'b0;
    for (int k = 0; k < 20 && !c_rvalid3; k++) tick();
    chk("t4_rv2_seen", {63'd0, c_rvalid3}, 64'd1);
    tick();

    // Reset in the middle of a core read: no response may ever appear
    c_req0 = 1'b1; c_addr0 = 10'd3;
    exp_g0.push_back(2'b10);
    tick();
    chk("t5_c1_gnt", {63'd0, c_gnt0}, 64'd1);
    c_req0 = 1'b0;
    tick();
    chk("t5_c2_busy", {63'd0, busy0}, 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy0}, 64'd0);
    chk("t5_rst_outs", {62'd0, m_en0, c_rvalid0}, 64'd0);
    chk("t5_rst_maddr", {54'd0, m_addr0}, 64'd0);
    chk("t5_rst_crdata", c_rdata0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_rvalid", {63'd0, c_rvalid0}, 64'd0);
    end
    c_req0 = 1'b1; c_addr0 = 10'd3;
    d_req0 = 1'b1; d_addr0 = 10'd2; d_we0 = 1'b0;
    exp_g0.push_back(2'b10);
    exp_c0.push_back(64'd2);
    rst = 1'b1;
    tick();
    chk("t5_post_cgnt", {63'd0, c_gnt0}, 64'd1);
    chk("t5_post_dgnt", {63'd0, d_gnt0}, 64'd0);
    c_req0 = 1'b0; d_req0 = 1'b0;
    repeat (4) tick();

    // Lone debug requester served back-to-back
    d_req0 = 1'b1; d_addr0 = 10'd2; d_we0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_g0.push_back(2'b01);
      exp_d0.push_back(64'd3);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      chk($sformatf("t6_dgnt_c%0d", cyc), {63'd0, d_gnt0},
          {63'd0, cyc == 1 || cyc == 5 || cyc == 9});
      chk($sformatf("t6_cquiet_c%0d", cyc), {62'd0, c_gnt0, c_rvalid0}, 64'd0);
    end
    d_req0 = 1'b0;
    repeat (5) tick();

    chk("sb_c0_empty", 64'(exp_c0.size()), 64'd0);
    chk("sb_d0_empty", 64'(exp_d0.size()), 64'd0);
    chk("sb_c3_empty", 64'(exp_c3.size()), 64'd0);
    chk("sb_g0_empty", 64'(exp_g0.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
